serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 start_i  input  1  request a new operation; sampled on rising edge.
REQ-005 A_i  input  WIDTH  operand A.
REQ-006 B_i  input  WIDTH  operand B.
REQ-007 C_in_i  input  1  carry-in for add operations.
REQ-008 sub_i  input  1  1 = A minus B, 0 = A plus B plus C_in_i.
REQ-009 S_o  output  WIDTH  result.
REQ-010 C_out_o  output  1  carry-out from the MSB; for subtract, 1 = no borrow.
REQ-011 V_o  output  1  signed overflow.
REQ-012 busy_o  output  1  operation in progress.
REQ-013 done_o  output  1  one-cycle pulse marking a valid result.

Function
REQ-014 The block SHALL have three states: IDLE, RUN, DONE.
REQ-015 A start is accepted when start_i=1 and the state is IDLE or DONE.
- On acceptance: latch A_i, B_i, sub_i, C_in_i; clear bit counter; go to RUN.
REQ-016 start_i SHALL be ignored in RUN; latched operands SHALL not change.
REQ-017 In RUN, one bit per cycle SHALL be processed LSB-first by a single 1-bit full-adder cell.
- Cell inputs: A[k], B[k] (B[k] inverted when sub=1), and the carry flip-flop.
- Sum bit SHALL shift into the result register from the MSB side.
- Cell carry-out SHALL update the carry flip-flop.
REQ-018 The carry flip-flop SHALL load C_in_i on acceptance for add, and 1 for subtract; C_in_i is ignored when sub_i=1.
REQ-019 RUN SHALL last exactly WIDTH cycles.
- The cycle processing bit WIDTH-1 transitions to DONE.
REQ-020 done_o SHALL be 1 only in DONE.
- Timing: done_o is high exactly WIDTH+1 rising edges after the accepting edge.
REQ-021 DONE SHALL last one cycle; then go to IDLE, or to RUN if start_i=1.
REQ-022 busy_o SHALL equal (state==RUN).
REQ-023 C_out_o SHALL be the carry out of bit WIDTH-1.
REQ-024 V_o SHALL be the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1; the carry into the MSB SHALL be captured during its cycle.
REQ-025 Output validity and hold:
- S_o, C_out_o, V_o are valid from the done_o cycle.
- They SHALL be held until the next accepted start.
- They are don't-care while busy_o=1.
REQ-026 Results SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-027 While rst_i=1 at a rising edge, the block SHALL go to IDLE and clear all internal state.
- Output values: S_o=0, C_out_o=0, V_o=0, busy_o=0, done_o=0.
REQ-028 Reset SHALL take priority over start_i and over any in-flight operation.
- An aborted operation SHALL produce no done_o pulse.
REQ-029 Reset SHALL have no effect until the next rising edge; there is no asynchronous path.

Structure
REQ-030 Shared package adder_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the constant ADDER_WIDTH_DEFAULT=8.
REQ-031 The bit cell SHALL be one instance of the existing Full_Adder module; no other sub-modules.
REQ-032 Counter width SHALL be $clog2(WIDTH)+1 bits; no combinational path from any input to any output.

Verification
REQ-033 WIDTH=8, add 0x5A+0x3C with C_in_i=0.
- Required: done_o at edge 9; S_o=0x96, C_out_o=0, V_o=1; busy_o high for exactly 8 cycles.
REQ-034 Subtract 0x10-0x20 (sub_i=1, C_in_i=0).
- Required: S_o=0xF0, C_out_o=0, V_o=0.
REQ-035 Add 0xFF+0x01 with C_in_i=0, then 0x7F+0x00 with C_in_i=1 issued in the DONE cycle.
- First result: S_o=0x00, C_out_o=1, V_o=0.
- Second result: S_o=0x80, V_o=1, done_o WIDTH+1 edges after DONE.
REQ-036 Start 0x01+0x01; at RUN cycle 3, pulse start_i with 0xAA+0x55.
- Required: second start ignored; S_o=0x02; exactly one done_o pulse.
REQ-037 Start 0x33+0x44; assert rst_i at RUN cycle 4 for one cycle.
- Required: next cycle shows IDLE with all outputs 0; no done_o for 20 cycles.
- A following start of 0x01+0x02 SHALL yield S_o=0x03.
REQ-038 Repeat REQ-033 with WIDTH=2.
- Stimulus: 0b11+0b01, C_in_i=0.
- Required: done_o at edge 3; S_o=0b00, C_out_o=1, V_o=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the controller state encoding and the default operand width.
package adder_pkg;

    localparam int ADDER_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/Full_Adder.sv
// One-bit full-adder cell.
// Used as the single arithmetic element of the serial adder.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one result bit per cycle, LSB first.
// Results are registered and held until the next accepted start.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             C_in_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] S_o,
    output logic             C_out_o,
    output logic             V_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-2:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             sub_q;
    logic             carry_q;
    logic             c_out_q;
    logic             v_q;
    logic             accept;
    logic             running;
    logic             fa_s;
    logic             fa_c;

    assign idx     = cnt_q[CW-2:0];
    assign running = (state_q == RUN);
    assign accept  = start_i && !running;

    Full_Adder u_fa (
        .a     (a_q[idx]),
        .b     (b_q[idx] ^ sub_q),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == RUN);
        done_o  = (state_q == DONE);
        S_o     = s_q;
        C_out_o = c_out_q;
        V_o     = v_q;
    end

    // Subtract is A + ~B + 1, so the carry seeds to 1 and C_in_i is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            v_q     <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            a_q     <= A_i;
            b_q     <= B_i;
            sub_q   <= sub_i;
            carry_q <= sub_i | C_in_i;
        end else if (running) begin
            s_q     <= {fa_s, s_q[WIDTH-1:1]};
            carry_q <= fa_c;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                c_out_q <= fa_c;
                v_q     <= carry_q ^ fa_c;
            end
        end
    end

endmodule
